// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch queue with in-order memory tracking and redirect flush
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        resp_err
);

  // Pointer width indexes DEPTH entries; counters need one extra bit to hold DEPTH itself.
  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [31:0]   fetch_pc_q;
  logic [31:0]   resp_pc_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic          resp_err_q;

  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic          credit_ok;
  logic          req_fire;
  logic          resp_hit;
  logic          resp_spurious;
  logic          push;
  logic          pop;
  logic [CW-1:0] redirect_drop;
  logic [31:0]   redirect_base;
  logic          unused_pc_bits;

  // Low address bits of a redirect are forced to zero, so they never reach any state.
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign redirect_base  = {redirect_pc[31:2], 2'b00};

  // Every queued entry plus every in-flight fetch holds a slot, so responses always fit.
  assign credit_ok = (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_C);

  // A response only counts against tracking when something is actually outstanding.
  assign resp_hit      = mem_resp_valid & (outstanding_q != '0);
  assign resp_spurious = mem_resp_valid & (outstanding_q == '0);
  assign req_fire      = mem_req_valid & mem_req_ready;

  // In RUN the drop count is always zero, so a hit outside a redirect cycle is real data.
  assign push = resp_hit & ~redirect & (drop_q == '0);
  assign pop  = instr_valid & instr_ready & ~redirect;

  // Whatever is still in flight after this cycle's response must be discarded on return.
  assign redirect_drop = outstanding_q - CW'(resp_hit);

  assign mem_req_addr = fetch_pc_q;
  assign instr_valid  = (count_q != '0);
  assign instr        = data_mem[head_q];
  assign instr_pc     = pc_mem[head_q];
  assign resp_err     = resp_err_q;

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and request-valid decode; redirect always restarts the flush decision.
  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    if ((state_q == RUN) && !redirect && !reset && credit_ok) begin
      mem_req_valid = 1'b1;
    end
    if (redirect) begin
      state_d = (redirect_drop != '0) ? FLUSH : RUN;
    end else if ((state_q == FLUSH) && resp_hit && (drop_q == CW'(1))) begin
      state_d = RUN;
    end
  end

  // Program counters, in-flight accounting and queue pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else if (redirect) begin
      fetch_pc_q    <= redirect_base;
      resp_pc_q     <= redirect_base;
      outstanding_q <= redirect_drop;
      drop_q        <= redirect_drop;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
      outstanding_q <= outstanding_q + CW'(req_fire) - CW'(resp_hit);
      if (resp_hit && (drop_q != '0)) begin
        drop_q <= drop_q - CW'(1);
      end
      if (push) begin
        tail_q    <= tail_q + PW'(1);
        resp_pc_q <= resp_pc_q + 32'd4;
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Queue storage; contents are don't-care until the count marks them valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      data_mem[tail_q] <= mem_resp_data;
      pc_mem[tail_q]   <= resp_pc_q;
    end
  end

  // Sticky flag for a response that arrives with no fetch in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_err_q <= 1'b0;
    end else if (resp_spurious) begin
      resp_err_q <= 1'b1;
    end
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning instruction queue entries and max in-flight-plus-buffered fetches; power of 2, range 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset; bits [1:0] are 00.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 redirect  input  1  one-cycle pulse: flush the queue and restart fetch at redirect_pc.
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 00.
REQ-007 mem_req_valid  output  1  fetch request to instruction memory.
REQ-008 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 mem_req_addr  output  32  word-aligned fetch address.
REQ-010 mem_resp_valid  input  1  response word valid; responses return in request order and are always accepted.
REQ-011 mem_resp_data  input  32  instruction word.
REQ-012 instr_valid  output  1  queue head holds an instruction.
REQ-013 instr  output  32  head instruction word.
REQ-014 instr_pc  output  32  address of head instruction.
REQ-015 instr_ready  input  1  core pops head when instr_valid=1.
REQ-016 resp_err  output  1  sticky: response received with no request outstanding.

Function
REQ-017 Internal state: fetch_pc, resp_pc (32b each), outstanding count, drop count, queue count, state in {RUN, FLUSH}.
REQ-018 mem_req_valid = (state==RUN) & ~redirect & ~reset & (count + outstanding < DEPTH); mem_req_addr = fetch_pc.
REQ-019 Request handshake (mem_req_valid & mem_req_ready): fetch_pc <= fetch_pc + 4 (mod 2^32), outstanding increments.
REQ-020 While mem_req_valid=1 and mem_req_ready=0, mem_req_addr holds stable; only redirect or reset may withdraw the request.
REQ-021 Non-dropped response (drop count 0, no redirect): push {resp_pc, mem_resp_data}, resp_pc <= resp_pc + 4, outstanding decrements.
REQ-022 Response with drop count > 0: data discarded, drop count and outstanding both decrement, resp_pc unchanged.
REQ-023 Queue outputs are registered: response at edge N yields instr_valid=1 from the cycle after edge N; minimum request-accept to instr_valid latency is 2 cycles with 1-cycle memory.
REQ-024 Pop (instr_valid & instr_ready) advances head; simultaneous push and pop leaves count unchanged; order strictly FIFO.
REQ-025 Queue never overflows: credit rule REQ-018 guarantees space for every outstanding response.
REQ-026 Redirect cycle: any response arriving is discarded; any pop is ignored; queue count <= 0; fetch_pc and resp_pc <= {redirect_pc[31:2],2'b00}; drop count <= outstanding - mem_resp_valid; outstanding <= same value.
REQ-027 After redirect: state <= FLUSH if new drop count > 0, else RUN.
REQ-028 FLUSH: no requests issued; each response decrements drop count; transition to RUN on the edge where drop count reaches 0; first new request in the following cycle.
REQ-029 Redirect during FLUSH: recomputed per REQ-026; later pc wins.
REQ-030 Response with outstanding==0: ignored, resp_err <= 1 and stays 1 until reset.
REQ-031 Wrap-around: fetch_pc/resp_pc 32'hFFFF_FFFC + 4 = 32'h0000_0000; queue pointers wrap modulo DEPTH.

Reset
REQ-032 reset high at a clock edge: fetch_pc, resp_pc <= RESET_PC; count, outstanding, drop count <= 0; state <= RUN; resp_err <= 0.
REQ-033 During the reset cycle mem_req_valid=0 and responses are ignored; after reset instr_valid=0 until the first response is pushed.
REQ-034 Reset mid-operation discards all queue contents and in-flight tracking; no drop accounting survives reset.

Verification
REQ-035 Streaming: ready=1, 1-cycle memory, instr_ready=1 -> instrs at pc 0,4,8,... one per cycle after 2-cycle startup, no gaps.
REQ-036 Backpressure: instr_ready=0, DEPTH=4 -> exactly 4 requests (0x0..0xC) accepted, then mem_req_valid=0; one pop -> one request to 0x10.
REQ-037 Redirect with 3 outstanding (3-cycle memory), redirect_pc=0x100 -> 3 responses dropped, state FLUSH, then first request 0x100, first instr_pc 0x100.
REQ-038 Redirect same cycle as a response with 2 outstanding -> that response dropped, drop count 1, queue empty next cycle.
REQ-039 Stall: mem_req_ready=0 for 5 cycles -> mem_req_addr constant, fetch_pc unchanged; redirect_pc=0x203 -> next request address 0x200.
REQ-040 Spurious mem_resp_valid after reset with nothing outstanding -> resp_err=1, instr_valid stays 0; reset clears resp_err.
